// File: rtl/mul_reservation_station.sv
// Reservation station for the MUL/DIV unit: holds issued ops, snoops the CDB for
// pending operands and dispatches the lowest-index ready entry once per cycle.
module mul_reservation_station #(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned TAG_W    = 3,
  parameter int unsigned TAG_BASE = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  output logic [TAG_W-1:0] issue_tag,
  input  logic             issue_op,
  input  logic [15:0]      issue_vj,
  input  logic [15:0]      issue_vk,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [15:0]      CDB,
  input  logic             fu_ready,
  output logic [15:0]      resv_out1,
  output logic [15:0]      resv_out2,
  output logic             OP,
  output logic             disp_valid,
  output logic [TAG_W-1:0] disp_tag
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             busy_q [DEPTH];
  logic             busy_d [DEPTH];
  logic             op_q   [DEPTH];
  logic             op_d   [DEPTH];
  logic [15:0]      vj_q   [DEPTH];
  logic [15:0]      vj_d   [DEPTH];
  logic [15:0]      vk_q   [DEPTH];
  logic [15:0]      vk_d   [DEPTH];
  logic [TAG_W-1:0] qj_q   [DEPTH];
  logic [TAG_W-1:0] qj_d   [DEPTH];
  logic [TAG_W-1:0] qk_q   [DEPTH];
  logic [TAG_W-1:0] qk_d   [DEPTH];

  logic [15:0]      out1_q, out1_d;
  logic [15:0]      out2_q, out2_d;
  logic             opo_q, opo_d;
  logic             dvalid_q, dvalid_d;
  logic [TAG_W-1:0] dtag_q, dtag_d;

  logic             alloc_found, disp_found;
  logic [IDX_W-1:0] alloc_idx, disp_idx;
  logic             issue_fire, disp_fire;

  // Allocation and readiness look only at registered state, so an entry freed
  // by dispatch cannot be refilled on the same edge.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    disp_found  = 1'b0;
    disp_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
      if (busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0 && !disp_found) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_ready = alloc_found;
  assign issue_tag   = alloc_found ? TAG_W'(TAG_BASE + alloc_idx) : '0;
  assign issue_fire  = issue_valid && alloc_found;
  assign disp_fire   = fu_ready && disp_found;

  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (busy_q[i]) begin
        if (cdb_valid && qj_q[i] != '0 && qj_q[i] == cdb_tag) begin
          vj_d[i] = CDB;
          qj_d[i] = '0;
        end
        if (cdb_valid && qk_q[i] != '0 && qk_q[i] == cdb_tag) begin
          vk_d[i] = CDB;
          qk_d[i] = '0;
        end
        if (disp_fire && disp_idx == IDX_W'(i)) busy_d[i] = 1'b0;
      end else if (issue_fire && alloc_idx == IDX_W'(i)) begin
        busy_d[i] = 1'b1;
        op_d[i]   = issue_op;
        if (cdb_valid && issue_qj != '0 && issue_qj == cdb_tag) begin
          vj_d[i] = CDB;
          qj_d[i] = '0;
        end else begin
          vj_d[i] = issue_vj;
          qj_d[i] = issue_qj;
        end
        if (cdb_valid && issue_qk != '0 && issue_qk == cdb_tag) begin
          vk_d[i] = CDB;
          qk_d[i] = '0;
        end else begin
          vk_d[i] = issue_vk;
          qk_d[i] = issue_qk;
        end
      end
    end
  end

  always_comb begin
    out1_d   = out1_q;
    out2_d   = out2_q;
    opo_d    = opo_q;
    dtag_d   = dtag_q;
    dvalid_d = 1'b0;
    if (disp_fire) begin
      out1_d   = vj_q[disp_idx];
      out2_d   = vk_q[disp_idx];
      opo_d    = op_q[disp_idx];
      dtag_d   = TAG_W'(TAG_BASE + disp_idx);
      dvalid_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        busy_q[i] <= 1'b0;
        op_q[i]   <= 1'b0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
      end
      out1_q   <= '0;
      out2_q   <= '0;
      opo_q    <= 1'b0;
      dvalid_q <= 1'b0;
      dtag_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      op_q     <= op_d;
      vj_q     <= vj_d;
      vk_q     <= vk_d;
      qj_q     <= qj_d;
      qk_q     <= qk_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
      opo_q    <= opo_d;
      dvalid_q <= dvalid_d;
      dtag_q   <= dtag_d;
    end
  end

  assign resv_out1  = out1_q;
  assign resv_out2  = out2_q;
  assign OP         = opo_q;
  assign disp_valid = dvalid_q;
  assign disp_tag   = dtag_q;
endmodule

// File: tb/tb_mul_reservation_station.sv
// Bench for mul_reservation_station: directed scenarios plus random traffic
// against a per-entry behavioural model of the station.
module tb_mul_reservation_station;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [2:0]  issue_tag;
  logic        issue_op = 1'b0;
  logic [15:0] issue_vj = '0, issue_vk = '0;
  logic [2:0]  issue_qj = '0, issue_qk = '0;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [15:0] CDB = '0;
  logic        fu_ready = 1'b1;
  logic [15:0] resv_out1, resv_out2;
  logic        OP, disp_valid;
  logic [2:0]  disp_tag;

  int passed = 0;
  int total  = 0;

  mul_reservation_station #(.DEPTH(3), .TAG_W(3), .TAG_BASE(4)) dut (
    .Clock(Clock), .Reset(Reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_tag(issue_tag), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .CDB(CDB), .fu_ready(fu_ready), .resv_out1(resv_out1), .resv_out2(resv_out2),
    .OP(OP), .disp_valid(disp_valid), .disp_tag(disp_tag)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        busy;
    logic        op;
    logic [15:0] vj, vk;
    logic [2:0]  qj, qk;
  } ent_t;

  ent_t        m [3];
  logic        m_dv, m_op;
  logic [15:0] m_o1, m_o2;
  logic [2:0]  m_dt;

  // One clock edge of the station, applied to the model from the current inputs.
  function automatic void model_edge();
    ent_t n [3];
    int   d, f;
    n = m;
    if (Reset) begin
      foreach (m[i]) m[i] = '{1'b0, 1'b0, 16'd0, 16'd0, 3'd0, 3'd0};
      m_dv = 0; m_op = 0; m_o1 = 0; m_o2 = 0; m_dt = 0;
      return;
    end
    d = -1;
    f = -1;
    for (int i = 2; i >= 0; i--) begin
      if (m[i].busy && m[i].qj == 0 && m[i].qk == 0) d = i;
      if (!m[i].busy) f = i;
    end
    if (fu_ready && d >= 0) begin
      m_dv = 1; m_o1 = m[d].vj; m_o2 = m[d].vk; m_op = m[d].op; m_dt = 3'(4 + d);
      n[d].busy = 0;
    end else begin
      m_dv = 0;
    end
    for (int i = 0; i < 3; i++) begin
      if (m[i].busy && cdb_valid && m[i].qj != 0 && m[i].qj == cdb_tag) begin
        n[i].vj = CDB; n[i].qj = 0;
      end
      if (m[i].busy && cdb_valid && m[i].qk != 0 && m[i].qk == cdb_tag) begin
        n[i].vk = CDB; n[i].qk = 0;
      end
    end
    if (issue_valid && f >= 0) begin
      n[f].busy = 1; n[f].op = issue_op;
      n[f].vj = issue_vj; n[f].qj = issue_qj;
      n[f].vk = issue_vk; n[f].qk = issue_qk;
      if (cdb_valid && issue_qj != 0 && issue_qj == cdb_tag) begin n[f].vj = CDB; n[f].qj = 0; end
      if (cdb_valid && issue_qk != 0 && issue_qk == cdb_tag) begin n[f].vk = CDB; n[f].qk = 0; end
    end
    m = n;
  endfunction

  function automatic logic m_ready();
    return !(m[0].busy && m[1].busy && m[2].busy);
  endfunction

  function automatic logic [2:0] m_tag();
    for (int i = 0; i < 3; i++) if (!m[i].busy) return 3'(4 + i);
    return 3'd0;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    Reset = 0; issue_valid = 0; cdb_valid = 0; fu_ready = 1;
    issue_qj = 0; issue_qk = 0;
  endtask

  task automatic do_issue(input logic op, input logic [15:0] vj, input logic [15:0] vk,
                          input logic [2:0] qj, input logic [2:0] qk);
    issue_valid = 1; issue_op = op; issue_vj = vj; issue_vk = vk; issue_qj = qj; issue_qk = qk;
  endtask

  task automatic test_reset();
    Reset = 1;
    tick();
    idle();
    total++; if (disp_valid !== 1'b0) $display("FAIL rst_dv got %0d exp 0", disp_valid); else passed++;
    total++; if (resv_out1 !== 16'd0 || resv_out2 !== 16'd0) $display("FAIL rst_out got %0h/%0h exp 0/0", resv_out1, resv_out2); else passed++;
    total++; if (OP !== 1'b0 || disp_tag !== 3'd0) $display("FAIL rst_op_tag got %0d/%0d exp 0/0", OP, disp_tag); else passed++;
    total++; if (issue_ready !== 1'b1 || issue_tag !== 3'd4) $display("FAIL rst_issue got %0d/%0d exp 1/4", issue_ready, issue_tag); else passed++;
  endtask

  task automatic test_ready_issue();
    do_issue(0, 16'd7, 16'd6, 0, 0);
    total++; if (issue_tag !== 3'd4) $display("FAIL rdy_issue_tag got %0d exp 4", issue_tag); else passed++;
    tick();
    idle();
    total++; if (disp_valid !== 1'b0) $display("FAIL rdy_early_dv got %0d exp 0", disp_valid); else passed++;
    tick();
    total++; if (disp_valid !== 1'b1 || disp_tag !== 3'd4) $display("FAIL rdy_disp got %0d/%0d exp 1/4", disp_valid, disp_tag); else passed++;
    total++; if (resv_out1 !== 16'd7 || resv_out2 !== 16'd6 || OP !== 1'b0)
      $display("FAIL rdy_ops got %0d/%0d/%0d exp 7/6/0", resv_out1, resv_out2, OP); else passed++;
    tick();
    total++; if (disp_valid !== 1'b0) $display("FAIL rdy_drop_dv got %0d exp 0", disp_valid); else passed++;
    total++; if (resv_out1 !== 16'd7 || disp_tag !== 3'd4) $display("FAIL rdy_hold got %0d/%0d exp 7/4", resv_out1, disp_tag); else passed++;
  endtask

  task automatic test_pending();
    do_issue(1, 16'($urandom), 16'd3, 3'd2, 3'd0);
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (disp_valid !== 1'b0) $display("FAIL pend_wait_dv got %0d exp 0", disp_valid); else passed++;
    end
    cdb_valid = 1; cdb_tag = 3'd2; CDB = 16'd12;
    tick();
    idle();
    total++; if (disp_valid !== 1'b0) $display("FAIL pend_capture_dv got %0d exp 0", disp_valid); else passed++;
    tick();
    total++; if (disp_valid !== 1'b1 || resv_out1 !== 16'd12 || resv_out2 !== 16'd3 || OP !== 1'b1)
      $display("FAIL pend_disp got %0d:%0d/%0d/%0d exp 1:12/3/1", disp_valid, resv_out1, resv_out2, OP); else passed++;
    tick();
  endtask

  task automatic test_bypass();
    do_issue(0, 16'd99, 16'd98, 3'd1, 3'd1);
    cdb_valid = 1; cdb_tag = 3'd1; CDB = 16'd5;
    tick();
    idle();
    tick();
    total++; if (disp_valid !== 1'b1 || resv_out1 !== 16'd5 || resv_out2 !== 16'd5)
      $display("FAIL bypass got %0d:%0d/%0d exp 1:5/5", disp_valid, resv_out1, resv_out2); else passed++;
    tick();
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 3; i++) begin
      do_issue(0, 16'(10 + i), 16'(20 + i), 3'(1 + i), 3'd0);
      tick();
    end
    idle();
    total++; if (issue_ready !== 1'b0 || issue_tag !== 3'd0) $display("FAIL full_ready got %0d/%0d exp 0/0", issue_ready, issue_tag); else passed++;
    do_issue(1, 16'd1, 16'd1, 3'd0, 3'd0);
    tick();
    idle();
    fu_ready = 0;
    tick();
    total++; if (disp_valid !== 1'b0) $display("FAIL full_dropped_dv got %0d exp 0", disp_valid); else passed++;
    cdb_valid = 1; cdb_tag = 3'd2; CDB = 16'd9;
    tick();
    cdb_valid = 0;
    tick(); tick();
    total++; if (disp_valid !== 1'b0 || issue_ready !== 1'b0) $display("FAIL stall got %0d/%0d exp 0/0", disp_valid, issue_ready); else passed++;
    fu_ready = 1;
    tick();
    total++; if (disp_valid !== 1'b1 || disp_tag !== 3'd5 || resv_out1 !== 16'd9 || resv_out2 !== 16'd21)
      $display("FAIL stall_release got %0d:%0d %0d/%0d exp 1:5 9/21", disp_valid, disp_tag, resv_out1, resv_out2); else passed++;
    total++; if (issue_ready !== 1'b1 || issue_tag !== 3'd5) $display("FAIL freed_ready got %0d/%0d exp 1/5", issue_ready, issue_tag); else passed++;
    cdb_valid = 1; cdb_tag = 3'd1; CDB = 16'd40;
    tick();
    cdb_tag = 3'd3; CDB = 16'd41;
    tick();
    idle();
    tick(); tick(); tick();
    total++; if (issue_ready !== 1'b1 || issue_tag !== 3'd4) $display("FAIL drain got %0d/%0d exp 1/4", issue_ready, issue_tag); else passed++;
  endtask

  task automatic test_priority();
    fu_ready = 0;
    do_issue(0, 16'd1, 16'd2, 0, 0); tick();
    do_issue(1, 16'd0, 16'd10, 3'd7, 0); tick();
    do_issue(0, 16'd3, 16'd4, 0, 0); tick();
    idle();
    tick();
    total++; if (disp_tag !== 3'd4 || resv_out1 !== 16'd1 || resv_out2 !== 16'd2)
      $display("FAIL prio_first got %0d %0d/%0d exp 4 1/2", disp_tag, resv_out1, resv_out2); else passed++;
    tick();
    total++; if (disp_valid !== 1'b1 || disp_tag !== 3'd6 || resv_out1 !== 16'd3)
      $display("FAIL prio_second got %0d:%0d %0d exp 1:6 3", disp_valid, disp_tag, resv_out1); else passed++;
    cdb_valid = 1; cdb_tag = 3'd7; CDB = 16'd11;
    tick();
    idle();
    tick();
    total++; if (disp_valid !== 1'b1 || disp_tag !== 3'd5 || resv_out1 !== 16'd11 || OP !== 1'b1)
      $display("FAIL prio_last got %0d:%0d %0d op%0d exp 1:5 11 op1", disp_valid, disp_tag, resv_out1, OP); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_issue(0, 16'd0, 16'd0, 3'd1, 0); tick();
    do_issue(0, 16'd0, 16'd0, 3'd2, 0); tick();
    do_issue(1, 16'd8, 16'd9, 0, 0); tick();
    idle();
    tick();
    total++; if (disp_valid !== 1'b1 || disp_tag !== 3'd6) $display("FAIL rmid_pre got %0d/%0d exp 1/6", disp_valid, disp_tag); else passed++;
    Reset = 1; do_issue(0, 16'd5, 16'd5, 0, 0); cdb_valid = 1; cdb_tag = 3'd1; CDB = 16'd3;
    tick();
    idle();
    total++; if (disp_valid !== 1'b0 || resv_out1 !== 16'd0 || resv_out2 !== 16'd0 || OP !== 1'b0 || disp_tag !== 3'd0)
      $display("FAIL rmid_outs got %0d %0d/%0d %0d %0d exp all 0", disp_valid, resv_out1, resv_out2, OP, disp_tag); else passed++;
    total++; if (issue_ready !== 1'b1 || issue_tag !== 3'd4) $display("FAIL rmid_issue got %0d/%0d exp 1/4", issue_ready, issue_tag); else passed++;
    for (int t = 1; t <= 3; t++) begin
      cdb_valid = 1; cdb_tag = 3'(t); CDB = 16'(t);
      tick();
      total++; if (disp_valid !== 1'b0) $display("FAIL rmid_ghost got %0d exp 0", disp_valid); else passed++;
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      Reset       = ($urandom_range(0, 99) == 0);
      issue_valid = $urandom_range(0, 1);
      issue_op    = $urandom_range(0, 1);
      issue_vj    = 16'($urandom);
      issue_vk    = 16'($urandom);
      issue_qj    = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(1, 7));
      issue_qk    = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(1, 7));
      cdb_valid   = $urandom_range(0, 1);
      cdb_tag     = 3'($urandom_range(1, 7));
      CDB         = 16'($urandom);
      fu_ready    = ($urandom_range(0, 3) != 0);
      #1;
      total++; if (issue_ready !== m_ready() || issue_tag !== m_tag())
        $display("FAIL rnd_issue c=%0d got %0d/%0d exp %0d/%0d", c, issue_ready, issue_tag, m_ready(), m_tag()); else passed++;
      tick();
      total++; if (disp_valid !== m_dv || disp_tag !== m_dt || resv_out1 !== m_o1 || resv_out2 !== m_o2 || OP !== m_op)
        $display("FAIL rnd_disp c=%0d got %0d:%0d %0h/%0h op%0d exp %0d:%0d %0h/%0h op%0d",
                 c, disp_valid, disp_tag, resv_out1, resv_out2, OP, m_dv, m_dt, m_o1, m_o2, m_op); else passed++;
    end
    idle();
  endtask

  initial begin
    foreach (m[i]) m[i] = '{1'b0, 1'b0, 16'd0, 16'd0, 3'd0, 3'd0};
    m_dv = 0; m_op = 0; m_o1 = 0; m_o2 = 0; m_dt = 0;
    @(negedge Clock);
    test_reset();
    test_ready_issue();
    test_pending();
    test_bypass();
    test_full_stall();
    test_priority();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
